mant_mul_seq: RTL
=================

# mant_mul_seq

Sequential shift-and-add unsigned multiplier for the mantissa path of the floating-point multiplier. It accepts two WIDTH-bit mantissas (hidden bit included) and retires one multiplier bit per cycle through the team's 32-bit ripple adder. After WIDTH iterations it presents the 2·WIDTH-bit product to the downstream normalise/round stage. A valid/ready handshake sits on both sides.

## Interface
- WIDTH, 24, mantissa width including hidden bit; legal range 2..31, limited by the 32-bit adder datapath.
- i_clk  input  1  rising-edge clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  operands valid.
- o_ready  output  1  block can accept operands; high only in IDLE.
- i_mcand  input  WIDTH  multiplicand mantissa.
- i_mplier  input  WIDTH  multiplier mantissa.
- o_valid  output  1  product valid; held until accepted.
- i_ready  input  1  downstream accepts product.
- o_product  output  2·WIDTH  unsigned product i_mcand × i_mplier.

## Operation
- State machine states:
  - IDLE: o_ready=1.
    - i_valid=1 at an edge: load mcand_r←i_mcand, acc_hi←0, mq←i_mplier, cnt←0; go to BUSY.
    - i_valid=0: stay in IDLE.
  - BUSY: one iteration per cycle. Each iteration:
    - sum[WIDTH:0] = mq[0] ? (acc_hi + mcand_r) : {1'b0, acc_hi}.
    - The addition uses one adder instance with operands zero-extended to 32 bits and i_carry=0. sum[WIDTH] is adder bit WIDTH; its o_carry is unused because it is always 0 for WIDTH≤31.
    - {acc_hi, mq} ← {sum, mq} >> 1, keeping the low 2·WIDTH bits. cnt←cnt+1.
    - When cnt==WIDTH−1, the iteration completes and the state goes to DONE.
  - DONE: o_valid=1 and o_product={acc_hi, mq}.
    - i_ready=1 at an edge: go to IDLE.
    - Otherwise: hold all state.
- Inputs are ignored outside IDLE. i_valid while BUSY or DONE has no effect; upstream must retry once o_ready=1.
- There is no DONE→BUSY bypass. A new operation is always accepted in IDLE, at least one cycle after the handshake.
- o_product is registered state. It holds its last value in IDLE and is only defined when o_valid=1.
- Arithmetic is exact and unsigned. There is no rounding, truncation or overflow, because the product fits in 2·WIDTH bits.
- Reset values, applied immediately on i_rst assertion, from any state:
  - State: IDLE.
  - o_ready=1, o_valid=0, o_product=0.
  - cnt=0, mcand_r=0.
  - An in-flight operation is discarded without any output.

## Timing
- Accept edge is T (IDLE, i_valid=1). BUSY occupies edges T+1..T+WIDTH.
- o_valid rises after edge T+WIDTH: 24 cycles from acceptance for WIDTH=24.
- o_ready falls after edge T and rises again the cycle after the output handshake edge.
- Minimum initiation interval: WIDTH+2 cycles.
- Critical path: one 32-bit ripple add plus a mux. There are no combinational paths from inputs to outputs.
- o_valid, o_product and o_ready are glitch-free register outputs. o_ready is decoded from the state register.

## Structure
- Shared package mul_pkg holds:
  - typedef enum {IDLE, BUSY, DONE} mul_state_e.
  - localparam MANT_W=24.
  - localparam ADD_W=32.
- Counter width is $clog2(WIDTH+1), computed locally.
- One sub-module instance: add_32bits, the existing team ripple adder. Operands are {zero-pad, acc_hi} and {zero-pad, mcand_r or 0}; i_carry is tied 0.
- Datapath registers: mcand_r, acc_hi, mq and cnt. These are all in this module.

## Test plan
- Basic product: 0x800000 × 0x800000 with i_ready=1 → o_valid 24 cycles after accept, o_product=0x400000000000, o_ready=1 on the next cycle.
- Full-scale product: 0xFFFFFF × 0xFFFFFF → o_product=0xFFFFFE000001. Also 0xABCDEF × 0x000001 → 0x000000ABCDEF.
- Zero operand and ignored input: 0x000000 × 0xABCDEF → 0x000000000000. During BUSY, drive i_valid=1 with 0x123456 × 0x654321; it must be ignored, and exactly one product appears.
- Backpressure: hold i_ready=0 for 10 cycles after o_valid rises → o_valid and o_product stay constant and o_ready stays 0. Raise i_ready → o_valid drops after that edge.
- Mid-operation reset: assert i_rst asynchronously in BUSY cycle 10 → o_valid=0, o_ready=1 and o_product=0 immediately. After release, 0x000003 × 0x000005 completes with 0x00000000000F.
- Randomised check: 1000 random operand pairs with random i_valid and i_ready gaps → every product matches the reference model, and each accept produces exactly one product.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and widths for the floating-point multiplier mantissa path.
package mul_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

   localparam int MANT_W = 24;
   localparam int ADD_W  = 32;

endpackage

// File: rtl/add_32bits.sv
// Team 32-bit ripple-carry adder: one full-adder cell per bit, carry rippling LSB to MSB.
module add_32bits (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_carry,
   output logic [31:0] o_sum,
   output logic        o_carry
);

   logic [32:0] carry;

   assign carry[0] = i_carry;

   for (genvar gi = 0; gi < 32; gi++) begin : g_fa
      assign o_sum[gi]     = i_a[gi] ^ i_b[gi] ^ carry[gi];
      assign carry[gi + 1] = (i_a[gi] & i_b[gi]) | (carry[gi] & (i_a[gi] ^ i_b[gi]));
   end

   assign o_carry = carry[32];

endmodule

// File: rtl/mant_mul_seq.sv
// Sequential shift-and-add mantissa multiplier: one multiplier bit per cycle,
// valid/ready on both the operand and product sides.
module mant_mul_seq
   import mul_pkg::*;
#(
   parameter int WIDTH = MANT_W
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [WIDTH-1:0]     i_mcand,
   input  logic [WIDTH-1:0]     i_mplier,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [2*WIDTH-1:0]   o_product
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   mul_state_e       state, state_nxt;
   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] mq;
   logic [CNT_W-1:0] cnt;
   logic             last_iter;

   logic [ADD_W-1:0] add_a, add_b, add_sum;
   logic             add_carry;
   logic [WIDTH:0]   sum;
   logic             unused_add;

   // Operands zero-extended into the 32-bit adder; WIDTH <= 31 keeps the sum's top bit in range.
   assign add_a = ADD_W'(acc_hi);
   assign add_b = mq[0] ? ADD_W'(mcand_r) : '0;

   add_32bits u_add (
      .i_a     (add_a),
      .i_b     (add_b),
      .i_carry (1'b0),
      .o_sum   (add_sum),
      .o_carry (add_carry)
   );

   assign sum        = add_sum[WIDTH:0];
   assign unused_add = add_carry ^ (^(add_sum >> (WIDTH + 1)));
   assign last_iter  = (cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_valid)   state_nxt = BUSY;
         BUSY:    if (last_iter) state_nxt = DONE;
         DONE:    if (i_ready)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mcand_r <= '0;
         acc_hi  <= '0;
         mq      <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: if (i_valid) begin
               mcand_r <= i_mcand;
               acc_hi  <= '0;
               mq      <= i_mplier;
               cnt     <= '0;
            end
            BUSY: begin
               // {acc_hi, mq} <= {sum, mq} >> 1; the retired multiplier bit falls off mq[0]
               acc_hi <= sum[WIDTH:1];
               mq     <= {sum[0], mq[WIDTH-1:1]};
               cnt    <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_ready   = (state == IDLE);
   assign o_valid   = (state == DONE);
   assign o_product = {acc_hi, mq};

endmodule
